// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the write-back stage.
// Contents:
//   DW, AW      default data and register-index widths
//   wb_state_t  write-back port scheduler state encoding
//   REG_ZERO    index of the hard-wired zero register
package pipeline_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } wb_state_t;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for write-back performance debug.
// Ports:
//   Clk    rising-edge clock
//   Rst    synchronous active-high reset, clears the count
//   inc    add one on this edge (ignored once all-ones)
//   count  current value, holds at all-ones
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: shares the single register-file write port between
// the primary result and the secondary (ALU2) result of double-write instructions.
// Single writes pass through with one registered cycle of latency; a double write
// stalls the pipeline for one cycle and issues the secondary write on the next.
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   MEMWB_*             instruction currently held in the MEM/WB buffer
//   RF_WriteEn/Reg/Data registered register-file write port
//   WB_Stall            combinational freeze of all pipeline buffers
//   WB_Busy             secondary write in progress
//   WB_WriteCount       committed writes, saturating
//   WB_StallCount       stall cycles issued, saturating
//
// state  | meaning
// IDLE   | pass primary result; stall and latch ALU2 on a double write
// SECOND | issue latched secondary write to WriteReg+1, inputs ignored
module wb_port_scheduler
  import pipeline_pkg::*;
#(
  parameter int DW = pipeline_pkg::DW,
  parameter int AW = pipeline_pkg::AW,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          MEMWB_RegWrite,
  input  logic          MEMWB_MemtoReg,
  input  logic [DW-1:0] MEMWB_DMReadData,
  input  logic [DW-1:0] MEMWB_ALUResult,
  input  logic [AW-1:0] MEMWB_WriteReg,
  input  logic          MEMWB_Double,
  input  logic [DW-1:0] MEMWB_ALU2,
  output logic          RF_WriteEn,
  output logic [AW-1:0] RF_WriteReg,
  output logic [DW-1:0] RF_WriteData,
  output logic          WB_Stall,
  output logic          WB_Busy,
  output logic [CW-1:0] WB_WriteCount,
  output logic [CW-1:0] WB_StallCount
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  wb_state_t     state_q, state_d;
  logic [DW-1:0] alu2_q;
  logic [AW-1:0] tgt2_q;

  logic          dbl;
  logic [DW-1:0] primary;
  logic          latch_second;
  logic          we_d;
  logic [AW-1:0] reg_d;
  logic [DW-1:0] data_d;
  logic          stall;

  assign dbl     = MEMWB_RegWrite & MEMWB_Double;
  assign primary = MEMWB_MemtoReg ? MEMWB_DMReadData : MEMWB_ALUResult;

  always_comb begin
    state_d      = state_q;
    latch_second = 1'b0;
    stall        = 1'b0;
    we_d         = 1'b0;
    reg_d        = MEMWB_WriteReg;
    data_d       = primary;
    case (state_q)
      IDLE: begin
        stall = dbl;
        we_d  = MEMWB_RegWrite & (MEMWB_WriteReg != ZERO_IDX);
        if (dbl) begin
          latch_second = 1'b1;
          state_d      = SECOND;
        end
      end
      SECOND: begin
        we_d    = (tgt2_q != ZERO_IDX);
        reg_d   = tgt2_q;
        data_d  = alu2_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Never freeze the pipeline while it is being reset.
    if (Rst) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      RF_WriteEn   <= 1'b0;
      RF_WriteReg  <= '0;
      RF_WriteData <= '0;
      alu2_q       <= '0;
      tgt2_q       <= '0;
    end else begin
      state_q      <= state_d;
      RF_WriteEn   <= we_d;
      RF_WriteReg  <= reg_d;
      RF_WriteData <= data_d;
      if (latch_second) begin
        alu2_q <= MEMWB_ALU2;
        // WriteReg = all-ones wraps to the zero register, whose write is dropped.
        tgt2_q <= MEMWB_WriteReg + AW'(1);
      end
    end
  end

  assign WB_Stall = stall;
  assign WB_Busy  = (state_q == SECOND);

  sat_counter #(.CW(CW)) u_write_count (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (we_d),
    .count (WB_WriteCount)
  );

  sat_counter #(.CW(CW)) u_stall_count (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (stall),
    .count (WB_StallCount)
  );

endmodule

// File: tb/tb_wb_port_scheduler.sv
module tb_wb_port_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          MEMWB_RegWrite;
  logic          MEMWB_MemtoReg;
  logic [DW-1:0] MEMWB_DMReadData;
  logic [DW-1:0] MEMWB_ALUResult;
  logic [AW-1:0] MEMWB_WriteReg;
  logic          MEMWB_Double;
  logic [DW-1:0] MEMWB_ALU2;
  logic          RF_WriteEn;
  logic [AW-1:0] RF_WriteReg;
  logic [DW-1:0] RF_WriteData;
  logic          WB_Stall;
  logic          WB_Busy;
  logic [CW-1:0] WB_WriteCount;
  logic [CW-1:0] WB_StallCount;

  int checks = 0;
  int failures = 0;

  wb_port_scheduler #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .MEMWB_RegWrite   (MEMWB_RegWrite),
    .MEMWB_MemtoReg   (MEMWB_MemtoReg),
    .MEMWB_DMReadData (MEMWB_DMReadData),
    .MEMWB_ALUResult  (MEMWB_ALUResult),
    .MEMWB_WriteReg   (MEMWB_WriteReg),
    .MEMWB_Double     (MEMWB_Double),
    .MEMWB_ALU2       (MEMWB_ALU2),
    .RF_WriteEn       (RF_WriteEn),
    .RF_WriteReg      (RF_WriteReg),
    .RF_WriteData     (RF_WriteData),
    .WB_Stall         (WB_Stall),
    .WB_Busy          (WB_Busy),
    .WB_WriteCount    (WB_WriteCount),
    .WB_StallCount    (WB_StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the port owes a queue of writes; a double pushes its
  // secondary write, and owed writes are served before any new instruction.
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           owed[$];
  bit            m_valid = 0;
  logic          m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;
  int            m_wcnt;
  int            m_scnt;

  always @(posedge Clk) begin
    wr_t w;
    if (Rst) begin
      owed.delete();
      m_we = 0; m_reg = 0; m_data = 0;
      m_wcnt = 0; m_scnt = 0;
      m_valid = 1;
    end else if (owed.size() > 0) begin
      w = owed.pop_front();
      m_we = (w.r != 0); m_reg = w.r; m_data = w.d;
      if (m_we && m_wcnt < CMAX) m_wcnt++;
    end else begin
      m_we   = MEMWB_RegWrite && (MEMWB_WriteReg != 0);
      m_reg  = MEMWB_WriteReg;
      m_data = MEMWB_MemtoReg ? MEMWB_DMReadData : MEMWB_ALUResult;
      if (m_we && m_wcnt < CMAX) m_wcnt++;
      if (MEMWB_RegWrite && MEMWB_Double) begin
        if (m_scnt < CMAX) m_scnt++;
        w.r = MEMWB_WriteReg + 5'd1;
        w.d = MEMWB_ALU2;
        owed.push_back(w);
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      check("stall", WB_Stall, !Rst && owed.size() == 0 && MEMWB_RegWrite && MEMWB_Double);
      check("busy", WB_Busy, owed.size() != 0);
      check("we", RF_WriteEn, m_we);
      check("wreg", RF_WriteReg, m_reg);
      check("wdata", RF_WriteData, m_data);
      check("wcnt", WB_WriteCount, m_wcnt);
      check("scnt", WB_StallCount, m_scnt);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    MEMWB_RegWrite = 0; MEMWB_MemtoReg = 0; MEMWB_Double = 0;
    MEMWB_DMReadData = 0; MEMWB_ALUResult = 0; MEMWB_ALU2 = 0; MEMWB_WriteReg = 0;
  endtask

  task automatic set_in(input logic rw, input logic m2r, input logic dbl, input logic [AW-1:0] wr,
                        input logic [DW-1:0] dm, input logic [DW-1:0] alu, input logic [DW-1:0] alu2);
    MEMWB_RegWrite = rw; MEMWB_MemtoReg = m2r; MEMWB_Double = dbl; MEMWB_WriteReg = wr;
    MEMWB_DMReadData = dm; MEMWB_ALUResult = alu; MEMWB_ALU2 = alu2;
  endtask

  initial begin
    // 1: reset with a double instruction presented
    Rst = 1;
    set_in(1, 0, 1, 5'd5, 32'h1, 32'h2, 32'h3);
    step(); step();
    check("rst_stall", WB_Stall, 0);
    check("rst_we", RF_WriteEn, 0);
    check("rst_wcnt", WB_WriteCount, 0);
    check("rst_scnt", WB_StallCount, 0);
    Rst = 0;
    idle_in();
    step();

    // 2: single ALU write
    set_in(1, 0, 0, 5'd8, 32'hDEAD_0000, 32'h0000_1234, 32'h0);
    step();
    check("single_we", RF_WriteEn, 1);
    check("single_reg", RF_WriteReg, 8);
    check("single_data", RF_WriteData, 32'h1234);
    check("single_wcnt", WB_WriteCount, 1);
    // single load write
    set_in(1, 1, 0, 5'd9, 32'hCAFE_0009, 32'h0, 32'h0);
    step();
    check("load_data", RF_WriteData, 32'hCAFE_0009);
    idle_in();
    step();

    // 3: double write
    set_in(1, 1, 1, 5'd10, 32'hAAAA_0001, 32'h0BAD_0BAD, 32'h5555_0002);
    #1;
    check("dbl_stall_on", WB_Stall, 1);
    step();
    check("dbl_p_we", RF_WriteEn, 1);
    check("dbl_p_reg", RF_WriteReg, 10);
    check("dbl_p_data", RF_WriteData, 32'hAAAA_0001);
    check("dbl_stall_off", WB_Stall, 0);
    check("dbl_busy", WB_Busy, 1);
    step();
    check("dbl_s_we", RF_WriteEn, 1);
    check("dbl_s_reg", RF_WriteReg, 11);
    check("dbl_s_data", RF_WriteData, 32'h5555_0002);
    check("dbl_scnt", WB_StallCount, 1);
    check("dbl_wcnt", WB_WriteCount, 4);
    idle_in();
    step();

    // 4: wrap to $0, write to $0, double without RegWrite
    set_in(1, 0, 1, 5'd31, 32'h0, 32'h3131_3131, 32'h0F0F_0000);
    step();
    check("wrap_p_we", RF_WriteEn, 1);
    check("wrap_p_reg", RF_WriteReg, 31);
    step();
    check("wrap_s_we", RF_WriteEn, 0);
    check("wrap_s_reg", RF_WriteReg, 0);
    check("wrap_wcnt", WB_WriteCount, 5);
    set_in(1, 0, 0, 5'd0, 32'h0, 32'h7777_7777, 32'h0);
    step();
    check("zero_we", RF_WriteEn, 0);
    check("zero_wcnt", WB_WriteCount, 5);
    set_in(0, 0, 1, 5'd12, 32'h0, 32'h1, 32'h2);
    #1;
    check("nop_dbl_stall", WB_Stall, 0);
    step();
    check("nop_dbl_busy", WB_Busy, 0);
    check("nop_dbl_we", RF_WriteEn, 0);
    idle_in();
    step();

    // 5: reset during SECOND
    set_in(1, 0, 1, 5'd3, 32'h0, 32'h0000_0303, 32'h0000_0404);
    step();
    check("mid_busy", WB_Busy, 1);
    Rst = 1;
    step();
    check("mid_we", RF_WriteEn, 0);
    check("mid_busy_clr", WB_Busy, 0);
    Rst = 0;
    idle_in();
    step();
    check("mid_after_busy", WB_Busy, 0);
    check("mid_after_we", RF_WriteEn, 0);

    // 6: 20 back-to-back doubles saturate both 4-bit counters
    set_in(1, 0, 1, 5'd4, 32'h0, 32'h4444_0000, 32'h5555_0000);
    repeat (40) step();
    check("sat_scnt", WB_StallCount, 4'hF);
    check("sat_wcnt", WB_WriteCount, 4'hF);
    repeat (6) step();
    check("sat_scnt_hold", WB_StallCount, 4'hF);
    check("sat_wcnt_hold", WB_WriteCount, 4'hF);
    idle_in();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
